// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stage enables, flush requests and FSM.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rt,
  input  logic [4:0]       exe_wr,
  input  logic             exe_regwrite,
  input  logic             exe_memtoreg,
  input  logic             exe_branch_taken,
  input  logic             exe_jump,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             id2exe_en,
  output logic             if2id_flush,
  output logic             id2exe_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_REDIR = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_lu;
  logic   w_redir;

  // $0 is hardwired, so a load targeting it can never create a dependency.
  assign w_lu = exe_regwrite & exe_memtoreg & (exe_wr != 5'd0) &
                ((exe_wr == id_rs) | (id_use_rt & (exe_wr == id_rt)));
  assign w_redir = exe_branch_taken | exe_jump;

  assign state = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    pc_en        = 1'b1;
    if2id_en     = 1'b1;
    id2exe_en    = 1'b1;
    if2id_flush  = 1'b0;
    id2exe_flush = 1'b0;
    w_next       = ST_RUN;
    unique case (r_state)
      ST_RUN, ST_WAIT: begin
        if (mem_busy) begin
          pc_en     = 1'b0;
          if2id_en  = 1'b0;
          id2exe_en = 1'b0;
          w_next    = ST_WAIT;
        end else if (w_redir) begin
          if2id_flush  = 1'b1;
          id2exe_flush = 1'b1;
          w_next       = ST_REDIR;
        end else if (w_lu) begin
          pc_en        = 1'b0;
          if2id_en     = 1'b0;
          id2exe_flush = 1'b1;
          w_next       = ST_STALL;
        end
      end
      default: begin
        // EXE holds a bubble here, so only memory back-pressure matters.
        if (mem_busy) begin
          pc_en     = 1'b0;
          if2id_en  = 1'b0;
          id2exe_en = 1'b0;
          w_next    = ST_WAIT;
        end
      end
    endcase
    if (clr) begin
      pc_en        = 1'b0;
      if2id_en     = 1'b0;
      id2exe_en    = 1'b0;
      if2id_flush  = 1'b1;
      id2exe_flush = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // if2id_flush outside reset is asserted only by the redirect decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (if2id_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
